// File: rtl/serial_adder_n.sv
// Bit-serial adder/subtractor: one full adder and one carry FF, LSB first, WIDTH cycles per operation.
// Optional bit-level observation ports are enabled by defining SERIAL_ADDER_BITOUT_EN.
module serial_adder_n #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
`ifdef SERIAL_ADDER_BITOUT_EN
  ,
  output logic             s_bit,
  output logic             c_bit,
  output logic             bit_valid
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, sum_sr;
  logic [CW-1:0]    cnt;
  logic             carry, cout_r, ovf_r;
  logic             accept, last, fa_s, fa_c;

  assign fa_s = a_sr[0] ^ b_sr[0] ^ carry;
  assign fa_c = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));
  assign last = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Subtraction is a + ~b + !cin, so the borrow-in enters inverted on the carry FF.
  always_ff @(posedge clock) begin
    if (reset) begin
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else if (accept) begin
      a_sr   <= a;
      b_sr   <= sub ? ~b : b;
      sum_sr <= '0;
      cnt    <= '0;
      carry  <= sub ? ~cin : cin;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else if (busy) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      sum_sr <= {fa_s, sum_sr[WIDTH-1:1]};
      carry  <= fa_c;
      cnt    <= cnt + 1'b1;
      // On the MSB, carry holds the carry into the MSB and fa_c the carry out.
      if (last) begin
        cout_r <= fa_c;
        ovf_r  <= carry ^ fa_c;
      end
    end
  end

  assign sum  = sum_sr;
  assign cout = cout_r;
  assign ovf  = ovf_r;

`ifdef SERIAL_ADDER_BITOUT_EN
  assign s_bit     = busy & fa_s;
  assign c_bit     = busy & fa_c;
  assign bit_valid = busy;
`endif

endmodule

// File: tb/tb_serial_adder_n.sv
// Scoreboard bench for serial_adder_n (WIDTH=8): stimulus pushes expected results, a monitor pops on handshake.
// Define SERIAL_ADDER_BITOUT_EN for both bench and RTL to cover the bit-level ports.
module tb_serial_adder_n;

  logic       clock, reset, in_valid, in_ready, sub, cin;
  logic       out_valid, out_ready, cout, ovf, busy;
  logic [7:0] a, b, sum;
`ifdef SERIAL_ADDER_BITOUT_EN
  logic       s_bit, c_bit, bit_valid;
  int         bv_cnt;
  logic [7:0] sbits;
`endif

  serial_adder_n #(.WIDTH(8)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
`ifdef SERIAL_ADDER_BITOUT_EN
    , .s_bit(s_bit), .c_bit(c_bit), .bit_valid(bit_valid)
`endif
  );

  typedef struct {
    logic [7:0] s;
    logic       c;
    logic       o;
    int         acc;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0, n_fail = 0, cyc = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: samples 1 time unit after each falling edge so stimulus drives settle first.
  logic       prev_valid = 1'b0;
  logic [7:0] hs;
  logic       hc, ho;
  always @(negedge clock) begin
    #1;
    if (reset) prev_valid = 1'b0;
    else begin
      if (out_valid) begin
        if (!prev_valid) begin
          if (q.size() > 0) chk("latency", 64'(cyc - q[0].acc), 64'd8);
        end else begin
          chk("hold_sum", 64'(sum), 64'(hs));
          chk("hold_cout_ovf", 64'({cout, ovf}), 64'({hc, ho}));
          chk("hold_in_ready", 64'(in_ready), 64'd0);
        end
        hs = sum; hc = cout; ho = ovf;
        if (out_ready) begin
          if (q.size() == 0) chk("unexpected_result", 64'd1, 64'd0);
          else begin
            exp_t e;
            e = q.pop_front();
            chk("sum", 64'(sum), 64'(e.s));
            chk("cout", 64'(cout), 64'(e.c));
            chk("ovf", 64'(ovf), 64'(e.o));
          end
        end
      end
      prev_valid = out_valid;
    end
`ifdef SERIAL_ADDER_BITOUT_EN
    if (!reset && bit_valid) begin
      if (bv_cnt < 8) sbits[bv_cnt[2:0]] = s_bit;
      bv_cnt++;
    end
`endif
  end

  // Offer operands from a falling edge; returns on the falling edge right after the accept edge.
  task automatic send(input logic [7:0] va, input logic [7:0] vb, input logic vs, input logic vc,
                      input logic [7:0] es, input logic ec, input logic eo);
    int t = 0;
    in_valid = 1'b1; a = va; b = vb; sub = vs; cin = vc;
    while (!in_ready && t < 40) begin
      @(negedge clock);
      t++;
    end
    if (!in_ready) chk("accept_timeout", 64'd1, 64'd0);
    q.push_back('{s: es, c: ec, o: eo, acc: cyc + 1});
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    a = 8'($urandom); b = 8'($urandom); sub = ~vs; cin = ~vc;
  endtask

  task automatic wait_done();
    int t = 0;
    while (q.size() != 0 && t < 40) begin
      @(negedge clock);
      t++;
    end
    if (q.size() != 0) begin
      chk("result_timeout", 64'(q.size()), 64'd0);
      q.delete();
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    chk({tag, "_out_valid_busy"}, 64'({out_valid, busy}), 64'd0);
    chk({tag, "_sum"}, 64'(sum), 64'd0);
    chk({tag, "_cout_ovf"}, 64'({cout, ovf}), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; sub = 1'b0; cin = 1'b0;
`ifdef SERIAL_ADDER_BITOUT_EN
    bv_cnt = 0; sbits = '0;
`endif
    repeat (3) @(negedge clock);
    check_idle("reset");
`ifdef SERIAL_ADDER_BITOUT_EN
    chk("reset_bitout", 64'({s_bit, c_bit, bit_valid}), 64'd0);
`endif
    reset = 1'b0;
    @(negedge clock);

    send(8'd100, 8'd27, 1'b0, 1'b0, 8'd127, 1'b0, 1'b0); wait_done();
    send(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0); wait_done();
    send(8'd127, 8'd1, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1); wait_done();
    send(8'd5, 8'd7, 1'b1, 1'b0, 8'hFE, 1'b0, 1'b0); wait_done();
    send(8'd7, 8'd5, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0); wait_done();
    send(8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1); wait_done();
    send(8'hF0, 8'h0F, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0); wait_done();

    // Back-pressure: result held 3 cycles while new operands are offered.
    out_ready = 1'b0;
    send(8'h40, 8'h40, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    begin
      int t = 0;
      while (!out_valid && t < 40) begin
        @(negedge clock);
        t++;
      end
      chk("hold_reached_done", 64'(out_valid), 64'd1);
    end
    in_valid = 1'b1; a = 8'd1; b = 8'd1; sub = 1'b0; cin = 1'b0;
    repeat (3) @(negedge clock);
    chk("hold_busy", 64'(busy), 64'd0);
    out_ready = 1'b1; in_valid = 1'b0;
    @(negedge clock);
    chk("hold_release_idle", 64'({in_ready, out_valid}), 64'b10);
    chk("hold_queue_drained", 64'(q.size()), 64'd0);

    // Reset sampled on the 4th RUN edge discards the operation.
    send(8'h55, 8'h22, 1'b0, 1'b0, 8'h77, 1'b0, 1'b0);
    repeat (3) @(negedge clock);
    chk("pre_reset_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge clock);
    check_idle("midrun_reset");
    q.delete();
    reset = 1'b0;
    send(8'd3, 8'd4, 1'b0, 1'b0, 8'd7, 1'b0, 1'b0); wait_done();

`ifdef SERIAL_ADDER_BITOUT_EN
    bv_cnt = 0; sbits = '0;
`endif
    send(8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0); wait_done();
`ifdef SERIAL_ADDER_BITOUT_EN
    chk("bit_valid_cycles", 64'(bv_cnt), 64'd8);
    chk("s_bit_sequence", 64'(sbits), 64'h10);
`endif

    repeat (3) @(negedge clock);
    chk("final_queue_empty", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder_n.md
SERIAL_ADDER_N -- requirements
Module: serial_adder_n

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand width in bits (legal range 2..64).
REQ-002 SHALL have port: clock  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: in_valid  input  1  operand set offered.
REQ-005 SHALL have port: in_ready  output  1  block can accept operands.
REQ-006 SHALL have port: a  input  WIDTH  operand A, unsigned or two's complement.
REQ-007 SHALL have port: b  input  WIDTH  operand B.
REQ-008 SHALL have port: sub  input  1  0 = add, 1 = subtract.
REQ-009 SHALL have port: cin  input  1  carry-in (add) or borrow-in (subtract).
REQ-010 SHALL have port: out_valid  output  1  result available.
REQ-011 SHALL have port: out_ready  input  1  consumer takes result.
REQ-012 SHALL have port: sum  output  WIDTH  result word.
REQ-013 SHALL have port: cout  output  1  final carry out; in subtract mode 1 = no borrow.
REQ-014 SHALL have port: ovf  output  1  signed overflow (carry into MSB XOR carry out of MSB).
REQ-015 SHALL have port: busy  output  1  high in RUN state.

Function
REQ-016 SHALL implement FSM states IDLE, RUN and DONE; the reset state is IDLE.
REQ-017 SHALL drive in_ready=1 only in IDLE; operands are accepted on a clock edge where in_valid && in_ready.
REQ-018 SHALL, on accept, latch a, b (b inverted when sub=1) and sub into shift registers, load the carry FF with cin (add) or !cin (sub), clear the bit counter, and move to RUN.
REQ-019 SHALL, in RUN, process exactly one bit per cycle, LSB first, through one full adder and one carry FF; the sum bit shifts into sum from the MSB end.
REQ-020 SHALL produce the result add: {cout,sum} = a + b + cin; sub: {cout,sum} = a + ~b + !cin (= a - b - cin).
REQ-021 SHALL size the bit counter at $clog2(WIDTH) bits; after the WIDTH-th bit (counter == WIDTH-1) go to DONE, with no wrap into further bits.
REQ-022 SHALL raise out_valid exactly WIDTH rising edges after the accepting edge, and hold it with sum, cout and ovf stable in DONE until out_valid && out_ready.
REQ-023 SHALL return to IDLE on the out_valid && out_ready edge; a new accept is possible no earlier than the following edge.
REQ-024 SHALL ignore in_valid in RUN and DONE, and SHALL ignore changes on a, b, sub and cin after accept.
REQ-025 SHALL not allow out_ready when out_valid=0 to change any state.
REQ-026 SHALL compute ovf from the carry into the MSB, captured during the last RUN cycle.

Reset
REQ-027 SHALL, when reset=1 at a rising edge, force IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0, ovf=0, clear the counter, carry FF and shift registers, and discard any operation in flight.
REQ-028 SHALL give reset priority over every simultaneous event, including accept and output handshake.

Configuration
REQ-029 SHALL use the macro SERIAL_ADDER_BITOUT_EN.
REQ-030 SHALL, when SERIAL_ADDER_BITOUT_EN is defined, add outputs s_bit (1), c_bit (1) and bit_valid (1), carrying the current full-adder sum bit, its carry and bit_valid=busy, for bit-level observation; all three are 0 after reset.
REQ-031 SHALL, when SERIAL_ADDER_BITOUT_EN is undefined, not have these ports, and all other behaviour SHALL be identical.

Verification (WIDTH=8)
REQ-032 SHALL cover: reset, then accept a=100, b=27, sub=0, cin=0 -> out_valid on the 8th edge after accept, sum=127, cout=0, ovf=0.
REQ-033 SHALL cover: a=8'hFF, b=8'h01, sub=0, cin=0 -> sum=8'h00, cout=1, ovf=0; then a=127, b=1 -> sum=8'h80, cout=0, ovf=1.
REQ-034 SHALL cover: a=5, b=7, sub=1, cin=0 -> sum=8'hFE, cout=0, ovf=0; then a=7, b=5, sub=1, cin=1 -> sum=1, cout=1.
REQ-035 SHALL cover: result ready, out_ready held low 3 cycles while in_valid=1 with new operands -> sum/cout/ovf held, in_ready=0, new operands not taken; on the out_ready edge -> IDLE.
REQ-036 SHALL cover: reset asserted on the 4th RUN cycle -> next cycle IDLE, out_valid=0, sum=0, in_ready=1; a following add of 3+4 gives 7.
REQ-037 SHALL cover: with SERIAL_ADDER_BITOUT_EN, a=8'h0F, b=8'h01 -> s_bit sequence (LSB first) 0,0,0,0,1,0,0,0 and bit_valid high for exactly 8 cycles.
